// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM copy master: copies `length` DATA_W words from src_addr to
// dst_addr, one read then one write per word, a single transaction in flight.
module avalon_mm_copy_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                readdatavalid,
    input  logic                waitrequest
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   data_q, data_d;
    // Read data already captured in the cycle the read was accepted.
    logic                got_q, got_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;

    assign busy       = busy_q;
    assign done       = done_q;
    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = '1;

    // Next-state, datapath and registered bus outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        got_d       = got_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = length;
                    got_d       = 1'b0;
                    state_d     = (length == '0) ? FIN : RD;
                end
            end
            RD: begin
                if (!waitrequest) begin
                    state_d = RD_WAIT;
                    // Zero-latency slave: data arrives with the accept.
                    if (readdatavalid) begin
                        data_d    = readdata;
                        src_ptr_d = src_ptr_q + STEP;
                        got_d     = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (got_q) begin
                    got_d   = 1'b0;
                    state_d = WR;
                end else if (readdatavalid) begin
                    data_d    = readdata;
                    src_ptr_d = src_ptr_q + STEP;
                    state_d   = WR;
                end
            end
            WR: begin
                if (!waitrequest) begin
                    dst_ptr_d   = dst_ptr_q + STEP;
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_d == '0) ? FIN : RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        read_d  = (state_d == RD);
        write_d = (state_d == WR);

        // Address/writedata only matter during a request; parked at 0 in IDLE.
        case (state_d)
            IDLE:    address_d = '0;
            RD:      address_d = src_ptr_d;
            WR:      address_d = dst_ptr_d;
            default: address_d = address_q;
        endcase
        case (state_d)
            IDLE:    writedata_d = '0;
            WR:      writedata_d = data_d;
            default: writedata_d = writedata_q;
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            got_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            got_q       <= got_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
        end
    end

endmodule
